// File: rtl/prbs31_burst_ctrl.sv
// PRBS31 (x^31 + x^28 + 1) burst generator with a self-synchronizing rx checker.
// Optional one-shot tx bit-error injection port when PRBS31_ERR_INJECT_EN is defined.
module prbs31_burst_ctrl #(
    parameter int          LEN_W    = 16,
    parameter int          ERR_W    = 16,
    parameter logic [30:0] SEED_DEF = 31'h7FFFFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             seed_load,
    input  logic [30:0]      seed,
    output logic             tx_bit,
    output logic             tx_valid,
    output logic             busy,
    output logic             done,
    input  logic             rx_bit,
    input  logic             rx_valid,
    input  logic             chk_clr,
`ifdef PRBS31_ERR_INJECT_EN
    input  logic             err_inj,
`endif
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_emit;
    logic [LEN_W-1:0]   r_cnt;
    logic [30:0]        r_lfsr;
    logic [30:0]        w_seed_val;
    logic [30:0]        w_lfsr_src;
    logic               w_load;
    logic               w_n;
    logic               w_inj;
    logic               r_tx_bit;
    logic [30:0]        r_chk;
    logic [4:0]         r_lock_cnt;
    logic [ERR_W-1:0]   r_err_cnt;
    logic               w_pred;

    assign w_load     = (r_state == S_IDLE) && seed_load;
    assign w_seed_val = (seed == 31'd0) ? SEED_DEF : seed;
    // A seed loaded in the same cycle as start feeds the very first emitted bit.
    assign w_lfsr_src = w_load ? w_seed_val : r_lfsr;
    assign w_n        = w_lfsr_src[30] ^ w_lfsr_src[27];

    // NOTE: every variable driven here gets a default first, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_emit       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_next_state = S_RUN;
                    w_emit       = 1'b1;
                end
            end
            S_RUN: begin
                if (abort)
                    w_next_state = S_IDLE;
                else if (r_cnt == LEN_W'(1))
                    w_next_state = S_DONE;
                else
                    w_emit = 1'b1;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

`ifdef PRBS31_ERR_INJECT_EN
    logic r_inj_arm;
    assign w_inj = r_inj_arm;

    // Pulses arriving while armed (including the cycle of use) are absorbed.
    always_ff @(posedge clk) begin
        if (rst || abort)
            r_inj_arm <= 1'b0;
        else if (r_inj_arm)
            r_inj_arm <= !w_emit;
        else
            r_inj_arm <= err_inj;
    end
`else
    assign w_inj = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_lfsr   <= SEED_DEF;
            r_tx_bit <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // A count of zero means continuous; finite bursts leave RUN at a count of one.
            if (r_state == S_IDLE && start && !abort)
                r_cnt <= cfg_len;
            else if (r_state == S_RUN && r_cnt != '0)
                r_cnt <= r_cnt - LEN_W'(1);
            if (w_emit) begin
                r_lfsr   <= {w_lfsr_src[29:0], w_n};
                r_tx_bit <= w_n ^ w_inj;
            end else if (w_load) begin
                r_lfsr <= w_seed_val;
            end
        end
    end

    assign tx_bit   = r_tx_bit;
    assign tx_valid = (r_state == S_RUN);
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);

    assign w_pred = r_chk[30] ^ r_chk[27];

    always_ff @(posedge clk) begin
        if (rst || chk_clr) begin
            r_chk      <= '0;
            r_lock_cnt <= '0;
            r_err_cnt  <= '0;
        end else if (rx_valid) begin
            r_chk <= {r_chk[29:0], rx_bit};
            if (r_lock_cnt != 5'd31)
                r_lock_cnt <= r_lock_cnt + 5'd1;
            if (locked && (rx_bit != w_pred) && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
    end

    assign locked  = (r_lock_cnt == 5'd31);
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_prbs31_burst_ctrl.sv
// Directed self-checking bench for prbs31_burst_ctrl with optional tx->rx loopback.
// Exercises the injection port too when PRBS31_ERR_INJECT_EN is defined.
module tb_prbs31_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] cfg_len;
    logic        seed_load;
    logic [30:0] seed;
    logic        tx_bit;
    logic        tx_valid;
    logic        busy;
    logic        done;
    logic        rx_bit;
    logic        rx_valid;
    logic        chk_clr;
    logic        err_inj;
    logic        locked;
    logic [15:0] err_cnt;

    logic        lb_en;
    logic        flip;
    logic        tb_rx_bit;
    logic        tb_rx_valid;

    int n_checks = 0;
    int n_errors = 0;

    assign rx_bit   = lb_en ? (tx_bit ^ flip) : tb_rx_bit;
    assign rx_valid = lb_en ? tx_valid : tb_rx_valid;

    always #5 clk = ~clk;

    prbs31_burst_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .cfg_len   (cfg_len),
        .seed_load (seed_load),
        .seed      (seed),
        .tx_bit    (tx_bit),
        .tx_valid  (tx_valid),
        .busy      (busy),
        .done      (done),
        .rx_bit    (rx_bit),
        .rx_valid  (rx_valid),
        .chk_clr   (chk_clr),
`ifdef PRBS31_ERR_INJECT_EN
        .err_inj   (err_inj),
`endif
        .locked    (locked),
        .err_cnt   (err_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if ({tx_bit, tx_valid, busy, done, locked} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b want 00000", {tx_bit, tx_valid, busy, done, locked});
        end
        n_checks++;
        if (err_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_err_cnt: got %0d want 0", err_cnt);
        end
    endtask

    // Seed 1: a 31-bit burst has ones only at bit indices 27 and 30.
    task automatic test_seed_one();
        logic exp_bit;
        seed_load = 1'b1;
        seed      = 31'h1;
        tick();
        seed_load = 1'b0;
        cfg_len   = 16'd31;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 31; i++) begin
            exp_bit = (i == 27 || i == 30);
            n_checks++;
            if ({tx_valid, tx_bit, done, busy} !== {1'b1, exp_bit, 1'b0, 1'b1}) begin
                n_errors++;
                $display("FAIL seed1_bit%0d: got v/b/d/busy=%b want %b", i,
                         {tx_valid, tx_bit, done, busy}, {1'b1, exp_bit, 1'b0, 1'b1});
            end
            tick();
        end
        n_checks++;
        if ({tx_valid, done, busy} !== 3'b011) begin
            n_errors++;
            $display("FAIL seed1_done: got v/d/busy=%b want 011", {tx_valid, done, busy});
        end
        tick();
        n_checks++;
        if ({done, busy} !== 2'b00) begin
            n_errors++;
            $display("FAIL seed1_idle: got d/busy=%b want 00", {done, busy});
        end
    endtask

    task automatic test_seed_zero();
        seed_load = 1'b1;
        seed      = 31'h0;
        tick();
        seed_load = 1'b0;
        cfg_len   = 16'd4;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({tx_valid, tx_bit} !== 2'b10) begin
                n_errors++;
                $display("FAIL seed0_bit%0d: got v/b=%b want 10", i, {tx_valid, tx_bit});
            end
            tick();
        end
        n_checks++;
        if ({tx_valid, done} !== 2'b01) begin
            n_errors++;
            $display("FAIL seed0_done: got v/d=%b want 01", {tx_valid, done});
        end
        tick();
        // Seed load together with start; a reload attempt mid-burst must be ignored.
        seed_load = 1'b1;
        seed      = 31'h1;
        cfg_len   = 16'd28;
        start     = 1'b1;
        tick();
        seed_load = 1'b0;
        start     = 1'b0;
        for (int i = 0; i < 28; i++) begin
            if (i == 5) begin
                seed_load = 1'b1;
                seed      = 31'h7FFFFFFF;
            end
            if (i == 6) seed_load = 1'b0;
            n_checks++;
            if ({tx_valid, tx_bit} !== {1'b1, (i == 27)}) begin
                n_errors++;
                $display("FAIL loadstart_bit%0d: got v/b=%b want %b", i, {tx_valid, tx_bit}, {1'b1, (i == 27)});
            end
            tick();
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_errors++;
            $display("FAIL loadstart_done: got %b want 1", done);
        end
        tick();
    endtask

    task automatic test_loopback();
        int n_valid;
        int n_done;
        lb_en     = 1'b1;
        seed_load = 1'b1;
        seed      = 31'h0;
        chk_clr   = 1'b1;
        tick();
        seed_load = 1'b0;
        chk_clr   = 1'b0;
        n_checks++;
        if ({locked, err_cnt} !== 17'd0) begin
            n_errors++;
            $display("FAIL lb_clear: got locked=%b err=%0d want 0/0", locked, err_cnt);
        end
        cfg_len = 16'd0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        n_valid = 0;
        n_done  = 0;
        for (int k = 1; k <= 200; k++) begin
            if (tx_valid) n_valid++;
            if (done) n_done++;
            if (k == 31) begin
                n_checks++;
                if (locked !== 1'b0) begin
                    n_errors++;
                    $display("FAIL lb_prelock: got %b want 0", locked);
                end
            end
            if (k == 32) begin
                n_checks++;
                if (locked !== 1'b1) begin
                    n_errors++;
                    $display("FAIL lb_lock: got %b want 1", locked);
                end
            end
            tick();
        end
        n_checks++;
        if (n_valid != 200 || n_done != 0 || err_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL lb_run: got valid=%0d done=%0d err=%0d want 200/0/0", n_valid, n_done, err_cnt);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if ({busy, tx_valid, done} !== 3'b000) begin
            n_errors++;
            $display("FAIL lb_abort: got busy/v/d=%b want 000", {busy, tx_valid, done});
        end
        tick();
        n_checks++;
        if (done !== 1'b0) begin
            n_errors++;
            $display("FAIL lb_abort_nodone: got %b want 0", done);
        end
    endtask

    task automatic test_error_count();
        cfg_len = 16'd0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 40; k++) tick();
        flip = 1'b1;
        tick();
        flip = 1'b0;
        for (int k = 0; k < 40; k++) tick();
        n_checks++;
        if ({locked, err_cnt} !== {1'b1, 16'd3}) begin
            n_errors++;
            $display("FAIL err_flip: got locked=%b err=%0d want 1/3", locked, err_cnt);
        end
        chk_clr = 1'b1;
        tick();
        chk_clr = 1'b0;
        n_checks++;
        if ({locked, err_cnt} !== 17'd0) begin
            n_errors++;
            $display("FAIL err_clr: got locked=%b err=%0d want 0/0", locked, err_cnt);
        end
        for (int k = 1; k <= 31; k++) begin
            tick();
            if (k == 30) begin
                n_checks++;
                if (locked !== 1'b0) begin
                    n_errors++;
                    $display("FAIL err_relock_early: got %b want 0", locked);
                end
            end
        end
        n_checks++;
        if (locked !== 1'b1) begin
            n_errors++;
            $display("FAIL err_relock: got %b want 1", locked);
        end
        for (int k = 0; k < 20; k++) tick();
        n_checks++;
        if (err_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL err_relock_clean: got %0d want 0", err_cnt);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL err_abort: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int n_valid;
        int n_done;
        lb_en   = 1'b0;
        cfg_len = 16'd10;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        n_valid = 0;
        n_done  = 0;
        for (int k = 1; k <= 25; k++) begin
            if (k == 3) begin
                start   = 1'b1;
                cfg_len = 16'd5;
            end
            if (k == 4) start = 1'b0;
            if (k == 11) start = 1'b1;
            if (k == 12) start = 1'b0;
            if (tx_valid) n_valid++;
            if (done) n_done++;
            tick();
        end
        n_checks++;
        if (n_valid != 10 || n_done != 1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_burst: got valid=%0d done=%0d busy=%b want 10/1/0", n_valid, n_done, busy);
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        n_checks++;
        if ({busy, tx_valid} !== 2'b00) begin
            n_errors++;
            $display("FAIL b2b_start_abort: got busy/v=%b want 00", {busy, tx_valid});
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_start_abort_hold: got %b want 0", busy);
        end
    endtask

`ifdef PRBS31_ERR_INJECT_EN
    task automatic test_inject();
        lb_en   = 1'b1;
        chk_clr = 1'b1;
        tick();
        chk_clr = 1'b0;
        cfg_len = 16'd0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 40; k++) tick();
        err_inj = 1'b1;
        tick();
        tick();
        err_inj = 1'b0;
        for (int k = 0; k < 40; k++) tick();
        n_checks++;
        if ({locked, err_cnt} !== {1'b1, 16'd3}) begin
            n_errors++;
            $display("FAIL inj_once: got locked=%b err=%0d want 1/3", locked, err_cnt);
        end
        abort = 1'b1;
        tick();
        abort   = 1'b0;
        cfg_len = 16'd50;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 55; k++) tick();
        n_checks++;
        if ({busy, err_cnt} !== {1'b0, 16'd3}) begin
            n_errors++;
            $display("FAIL inj_clean_burst: got busy=%b err=%0d want 0/3", busy, err_cnt);
        end
    endtask
`endif

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        cfg_len     = 16'd0;
        seed_load   = 1'b0;
        seed        = 31'h0;
        chk_clr     = 1'b0;
        err_inj     = 1'b0;
        lb_en       = 1'b0;
        flip        = 1'b0;
        tb_rx_bit   = 1'b0;
        tb_rx_valid = 1'b0;

        test_reset();
        test_seed_one();
        test_seed_zero();
        test_loopback();
        test_error_count();
        test_back_to_back();
`ifdef PRBS31_ERR_INJECT_EN
        test_inject();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prbs31_burst_ctrl.md
Name: prbs31_burst_ctrl

Overview:
- Sequenced PRBS31 pattern engine for the tile: a controller FSM runs an internal PRBS31 LFSR (x^31 + x^28 + 1) to emit length-programmed bursts on a serial tx stream.
- A self-synchronizing checker on the rx stream acquires lock and counts bit errors.
- Sits between the tile pin mux (cfg, seed, start/abort from ui_in/uio_in) and the serial output pins.

Parameters:
- LEN_W, 16, width of burst-length config and internal burst counter.
- ERR_W, 16, width of saturating error counter.
- SEED_DEF, 31'h7FFFFFFF, LFSR value after reset and substitute for an all-zero seed.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin burst (sampled in IDLE only).
- abort  in  1  terminate burst in RUN.
- cfg_len  in  LEN_W  burst length in bits; 0 = continuous until abort.
- seed_load  in  1  load seed into LFSR (IDLE only).
- seed  in  31  seed value.
- tx_bit  out  1  generated PRBS bit.
- tx_valid  out  1  tx_bit valid this cycle.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse at normal burst completion.
- rx_bit  in  1  received bit.
- rx_valid  in  1  rx_bit valid this cycle.
- chk_clr  in  1  clear checker lock and error count.
- locked  out  1  checker acquired.
- err_cnt  out  ERR_W  saturating error count.

Behaviour:
- Reset (rst=1 at edge): FSM=IDLE, LFSR=SEED_DEF, burst counter=0, tx_bit=0, tx_valid=0, busy=0, done=0, checker reg=0, lock counter=0, locked=0, err_cnt=0.
- LFSR step: s[30:0]; n = s[30]^s[27]; s <= {s[29:0], n}; tx_bit = n, registered and presented with tx_valid. The LFSR steps only on cycles where tx_valid is asserted.
- LFSR state persists across bursts, so the sequence continues, unless reseeded.
- seed_load in IDLE: LFSR <= seed, or SEED_DEF if seed == 0. seed_load outside IDLE is ignored.
- seed_load and start in the same IDLE cycle: the seed is loaded and the burst starts from the new seed.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start=1 and abort=0. cfg_len is latched into the burst counter on this transition.
- RUN: tx_valid=1 every cycle.
  - With nonzero length L: exactly L valid bits, then -> DONE.
  - With L=0: stays in RUN until abort.
  - abort=1 in RUN -> IDLE next cycle. The bit in that cycle is still valid; no done pulse.
- DONE: tx_valid=0, done=1 for one cycle, -> IDLE. abort is ignored in DONE.
- Timing: start sampled at edge t gives tx_valid high for cycles t+1..t+L, done at t+L+1, busy high t+1..t+L+1.
- start while busy is ignored (not queued). start and abort together in IDLE: stay in IDLE.
- Checker: 31-bit register c, advances only on rx_valid.
  - Prediction p = c[30]^c[27].
  - Always c <= {c[29:0], rx_bit} (self-synchronizing).
  - Lock counter counts rx_valid bits to 31, then locked=1 and holds.
  - Once locked, each rx_valid with rx_bit != p increments err_cnt. A single flipped bit therefore yields exactly 3 errors.
  - err_cnt saturates at all-ones.
- chk_clr: synchronous clear of c, lock counter, locked and err_cnt. It has priority over a simultaneous rx_valid, and it does not affect the generator.
- The checker runs independently of the FSM state.

Optional Feature:
- Macro: PRBS31_ERR_INJECT_EN.
- Defined: adds input port err_inj (1 bit).
  - A pulse arms a one-shot flag; the next emitted tx_bit is inverted on the output only. LFSR state is unaffected.
  - The flag clears when used, and also on rst or on abort.
  - Multiple pulses before use still inject once.
- Undefined: no err_inj port; tx_bit is always the true sequence.

Test Plan:
- Reset then seed_load seed=31'h1, start with cfg_len=31 -> exactly 31 tx_valid cycles; tx bits with indices 27 and 30 are 1, all others 0; done pulses once at cycle 32 after start; busy deasserts the cycle after done.
- seed_load seed=0, then start with cfg_len=4 -> sequence identical to the one after reset from SEED_DEF: first bits 0,0,0,0.
- Loopback tx->rx, SEED_DEF, cfg_len=0, run 200 cycles then abort -> locked after 31 valid bits, err_cnt=0, no done pulse, IDLE next cycle.
- Loopback with one rx bit forced inverted after lock -> err_cnt=3. Then chk_clr -> err_cnt=0, locked=0, relock after 31 bits.
- start pulsed again during RUN with cfg_len=10, plus start+abort together in IDLE -> second start ignored, 10 valid bits only; start+abort leaves busy=0.
- PRBS31_ERR_INJECT_EN defined, loopback, err_inj pulsed twice after lock -> err_cnt=3 (single injection); next burst clean.
